// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit, 4-register CPU control path.
// Opcodes, sequencer state encoding and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 6;
    localparam int RS_MSB   = 5;
    localparam int RS_LSB   = 4;
    localparam int RT_MSB   = 3;
    localparam int RT_LSB   = 2;
    localparam int RD_MSB   = 1;
    localparam int RD_LSB   = 0;
    localparam int JOFF_MSB = 5;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Board/datapath-facing signal bundle of the sequencer: run controls,
// instruction-memory port, decoded fields and control strobes.
interface cpu_sequencer_if;

    logic       start;
    logic       step_mode;
    logic       step;
    logic       halt_req;
    logic [7:0] imem_addr;
    logic [7:0] instruction;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] state;
    logic       halted;
    logic       paused;

    modport master (
        input  start, step_mode, step, halt_req, instruction,
        output imem_addr, pc, ir, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src,
               state, halted, paused
    );

    modport slave (
        output start, step_mode, step, halt_req, instruction,
        input  imem_addr, pc, ir, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src,
               state, halted, paused
    );

endinterface

// File: rtl/cpu_sequencer_instr_decode.sv
// Purely combinational field splitter for the latched instruction register.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir_i,
    output opcode_e    opcode_o,
    output logic [1:0] rs_o,
    output logic [1:0] rt_o,
    output logic [1:0] rd_o,
    output logic [7:0] imm_o,
    output logic [7:0] joff_o
);

    assign opcode_o = opcode_e'(ir_i[OPC_MSB:OPC_LSB]);
    assign rs_o     = ir_i[RS_MSB:RS_LSB];
    assign rt_o     = ir_i[RT_MSB:RT_LSB];
    assign rd_o     = ir_i[RD_MSB:RD_LSB];
    assign imm_o    = {{6{ir_i[RD_MSB]}}, ir_i[RD_MSB:RD_LSB]};
    assign joff_o   = {{2{ir_i[JOFF_MSB]}}, ir_i[JOFF_MSB:0]};

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR, with
// start / single-step / halt run control.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PROG_LEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    cpu_sequencer_if.master bus
);

    localparam logic [8:0] PROG_END = 9'(PROG_LEN);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    opcode_e    opcode;
    logic [7:0] joff;
    logic       fetch_ok;
    state_e     instr_end;

    instr_decode u_decode (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .rs_o     (bus.rs),
        .rt_o     (bus.rt),
        .rd_o     (bus.rd),
        .imm_o    (bus.imm),
        .joff_o   (joff)
    );

    assign fetch_ok  = {1'b0, pc_q} < PROG_END;
    assign instr_end = bus.halt_req  ? S_HALT  :
                       bus.step_mode ? S_PAUSE : S_FETCH;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (!fetch_ok) begin
                    state_d = S_HALT;
                end else begin
                    ir_d    = bus.instruction;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (opcode)
                    OP_ADD:       state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_J: begin
                        pc_d    = pc_q + joff;
                        state_d = instr_end;
                    end
                endcase
            end
            S_MEM:   state_d = (opcode == OP_LW) ? S_WB : instr_end;
            S_WB:    state_d = instr_end;
            S_PAUSE: begin
                if (bus.halt_req)                      state_d = S_HALT;
                else if (bus.step || !bus.step_mode)   state_d = S_FETCH;
            end
            S_HALT: begin
                if (bus.start && !bus.halt_req) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
        endcase
    end

    // Strobes decode from registered state and IR only, so reset clears them at once.
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.state      = state_q;
    assign bus.reg_write  = (state_q == S_WB);
    assign bus.mem_read   = (state_q == S_MEM) && (opcode == OP_LW);
    assign bus.mem_write  = (state_q == S_MEM) && (opcode == OP_SW);
    assign bus.mem_to_reg = (state_q == S_WB)  && (opcode == OP_LW);
    assign bus.alu_src    = ((state_q == S_EXEC) || (state_q == S_MEM)) &&
                            ((opcode == OP_LW) || (opcode == OP_SW));
    assign bus.halted     = (state_q == S_HALT);
    assign bus.paused     = (state_q == S_PAUSE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: decode table, directed corner
// sequences and random programs against an instruction-level model.
module tb_cpu_sequencer;

    localparam int PLEN = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] imem [256];
    int n_checks = 0;
    int n_err = 0;

    cpu_sequencer_if bus();

    cpu_sequencer #(.PROG_LEN(PLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.instruction = imem[bus.imem_addr];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] instr;
        logic [7:0] next_pc;
        int         lat;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
        logic [7:0] imm;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.step_mode = 1'b0;
        bus.halt_req  = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    // Instruction-level model: cycles FETCH->next FETCH and per-instruction strobe cycles.
    task automatic profile(input logic [7:0] b, output int lat, output int rw, output int mr,
                           output int mw, output int alu, output int m2r);
        rw = 0; mr = 0; mw = 0; alu = 0; m2r = 0;
        case (b[7:6])
            2'd0: begin lat = 4; rw = 1; end
            2'd1: begin lat = 5; rw = 1; mr = 1; alu = 2; m2r = 1; end
            2'd2: begin lat = 4; mw = 1; alu = 2; end
            default: lat = 3;
        endcase
    endtask

    function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [7:0] b);
        int off;
        if (b[7:6] != 2'd3) return pc + 8'd1;
        off = int'(b[5:0]);
        if (off > 31) off -= 64;
        return 8'((int'(pc) + 1 + off) & 255);
    endfunction

    // Called while the DUT sits in FETCH; follows it to the next FETCH/PAUSE/HALT.
    task automatic run_instr(input string nm, input logic [7:0] exp_pc, input logic [2:0] exp_end,
                             output int rw_at, output int mr_at, output int mw_at);
        int lat, erw, emr, emw, ealu, em2r;
        int n, rw, mr, mw, alu, m2r;
        profile(imem[exp_pc], lat, erw, emr, emw, ealu, em2r);
        check({nm, " fetch state"}, 32'(bus.state), 32'd1);
        check({nm, " fetch pc"}, 32'(bus.pc), 32'(exp_pc));
        check({nm, " imem_addr"}, 32'(bus.imem_addr), 32'(exp_pc));
        check({nm, " fetch strobes"}, 32'({bus.reg_write, bus.mem_write}), 32'd0);
        n = 0; rw = 0; mr = 0; mw = 0; alu = 0; m2r = 0;
        rw_at = 0; mr_at = 0; mw_at = 0;
        do begin
            tick();
            n++;
            if (bus.reg_write)  begin rw++; if (rw_at == 0) rw_at = n + 1; end
            if (bus.mem_read)   begin mr++; if (mr_at == 0) mr_at = n + 1; end
            if (bus.mem_write)  begin mw++; if (mw_at == 0) mw_at = n + 1; end
            if (bus.alu_src)    alu++;
            if (bus.mem_to_reg) m2r++;
        end while (!(bus.state inside {3'd1, 3'd6, 3'd7}) && n < 12);
        check({nm, " latency"}, n, lat);
        check({nm, " reg_write cycles"}, rw, erw);
        check({nm, " mem_read cycles"}, mr, emr);
        check({nm, " mem_write cycles"}, mw, emw);
        check({nm, " alu_src cycles"}, alu, ealu);
        check({nm, " mem_to_reg cycles"}, m2r, em2r);
        check({nm, " end state"}, 32'(bus.state), 32'(exp_end));
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " pc"}, 32'(bus.pc), 32'd0);
        check({nm, " ir"}, 32'(bus.ir), 32'd0);
        check({nm, " state"}, 32'(bus.state), 32'd0);
        check({nm, " fields"}, 32'({bus.rs, bus.rt, bus.rd, bus.imm}), 32'd0);
        check({nm, " controls"}, 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                                      bus.alu_src, bus.halted, bus.paused}), 32'd0);
    endtask

    initial begin
        int ra, ma, wa;
        logic [7:0] mpc;
        logic [7:0] prog [PLEN];
        int hk;
        bit done;

        vecs[0] = '{8'h49, 8'h01, 5, 2'd0, 2'd2, 2'd1, 8'h01};
        vecs[1] = '{8'h18, 8'h01, 4, 2'd1, 2'd2, 2'd0, 8'h00};
        vecs[2] = '{8'hA9, 8'h01, 4, 2'd2, 2'd2, 2'd1, 8'h01};
        vecs[3] = '{8'h4D, 8'h01, 5, 2'd0, 2'd3, 2'd1, 8'h01};
        vecs[4] = '{8'hFF, 8'h00, 3, 2'd3, 2'd3, 2'd3, 8'hFF};
        vecs[5] = '{8'hC1, 8'h02, 3, 2'd0, 2'd0, 2'd1, 8'h01};
        vecs[6] = '{8'h3E, 8'h01, 4, 2'd3, 2'd3, 2'd2, 8'hFE};
        vecs[7] = '{8'hE0, 8'hE1, 3, 2'd2, 2'd0, 2'd0, 8'h00};

        do_reset();
        check_reset_outputs("reset");

        // Single-instruction table at PC 0.
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_reset();
            imem[0] = vecs[i].instr;
            pulse_start();
            run_instr(nm, 8'h00, 3'd1, ra, ma, wa);
            check({nm, " next pc"}, 32'(bus.pc), 32'(vecs[i].next_pc));
            check({nm, " latency table"}, 32'(vecs[i].lat), 32'(vecs[i].instr[7:6] == 2'd1 ? 5 :
                                                              vecs[i].instr[7:6] == 2'd3 ? 3 : 4));
            check({nm, " rs"}, 32'(bus.rs), 32'(vecs[i].rs));
            check({nm, " rt"}, 32'(bus.rt), 32'(vecs[i].rt));
            check({nm, " rd"}, 32'(bus.rd), 32'(vecs[i].rd));
            check({nm, " imm"}, 32'(bus.imm), 32'(vecs[i].imm));
            if (vecs[i].next_pc >= 8'(PLEN)) begin
                tick();
                check({nm, " halted"}, 32'(bus.halted), 32'd1);
                check({nm, " halt state"}, 32'(bus.state), 32'd7);
            end
        end

        // Program walk with a skipped byte and halt at end of program.
        do_reset();
        imem[0] = 8'h49; imem[1] = 8'hC1; imem[2] = 8'h18; imem[3] = 8'hA9; imem[4] = 8'h4D;
        pulse_start();
        run_instr("prog lw0", 8'h00, 3'd1, ra, ma, wa);
        check("prog lw0 mem_read cycle", ma, 4);
        check("prog lw0 reg_write cycle", ra, 5);
        run_instr("prog j1", 8'h01, 3'd1, ra, ma, wa);
        run_instr("prog sw3", 8'h03, 3'd1, ra, ma, wa);
        check("prog sw3 mem_write cycle", wa, 4);
        run_instr("prog lw4", 8'h04, 3'd1, ra, ma, wa);
        check("prog end pc", 32'(bus.pc), 32'd5);
        tick();
        check("prog halted", 32'(bus.halted), 32'd1);
        check("prog ir kept", 32'(bus.ir), 32'h4D);

        // Single-step mode.
        do_reset();
        imem[0] = 8'h18;
        bus.step_mode = 1'b1;
        pulse_start();
        run_instr("step add", 8'h00, 3'd6, ra, ma, wa);
        check("step paused pc", 32'(bus.pc), 32'd1);
        check("step paused flag", 32'(bus.paused), 32'd1);
        repeat (3) tick();
        check("step hold state", 32'(bus.state), 32'd6);
        check("step hold pc", 32'(bus.pc), 32'd1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("step release state", 32'(bus.state), 32'd1);
        run_instr("step add2", 8'h01, 3'd6, ra, ma, wa);
        bus.step_mode = 1'b0;
        tick();
        check("step_mode drop state", 32'(bus.state), 32'd1);
        check("step_mode drop pc", 32'(bus.pc), 32'd2);

        // halt_req raised in DECODE of lw.
        do_reset();
        imem[0] = 8'h49;
        pulse_start();
        tick();
        check("halt decode state", 32'(bus.state), 32'd2);
        bus.halt_req = 1'b1;
        tick();
        tick();
        check("halt mem_read", 32'(bus.mem_read), 32'd1);
        tick();
        check("halt wb reg_write", 32'(bus.reg_write), 32'd1);
        tick();
        check("halt entered", 32'(bus.halted), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("halt start blocked", 32'(bus.state), 32'd7);
        bus.halt_req = 1'b0;
        tick();
        pulse_start();
        check("halt restart state", 32'(bus.state), 32'd1);
        check("halt restart pc", 32'(bus.pc), 32'd0);

        // Asynchronous reset in MEM of sw.
        do_reset();
        imem[0] = 8'hA9;
        pulse_start();
        repeat (3) tick();
        check("rst mem state", 32'(bus.state), 32'd4);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        tick();
        reset_n = 1'b1;

        // Random programs against the instruction-level model.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < PLEN; i++) begin
                prog[i] = 8'($urandom);
                imem[i] = prog[i];
            end
            hk = int'($urandom_range(0, 11));
            pulse_start();
            mpc = 8'h00;
            done = 1'b0;
            for (int k = 0; k < 12 && !done; k++) begin
                string nm;
                nm = $sformatf("rnd%0d.%0d", r, k);
                if (mpc >= 8'(PLEN)) begin
                    check({nm, " end fetch state"}, 32'(bus.state), 32'd1);
                    check({nm, " end pc"}, 32'(bus.pc), 32'(mpc));
                    tick();
                    check({nm, " end halted"}, 32'(bus.halted), 32'd1);
                    done = 1'b1;
                end else begin
                    bus.halt_req = (k == hk);
                    run_instr(nm, mpc, (k == hk) ? 3'd7 : 3'd1, ra, ma, wa);
                    bus.halt_req = 1'b0;
                    if (k == hk) done = 1'b1;
                    mpc = model_next_pc(mpc, prog[mpc]);
                end
            end
            check($sformatf("rnd%0d halted", r), 32'(bus.halted), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
